// File: rtl/counter_readback.sv
// Read-side datapath of the 8254 timer: decodes latch and read-back commands,
// holds per-counter count/status snapshots and sequences LSB/MSB reads onto the bus.
module counter_readback #(
    parameter int NUM_CNT = 3,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cw_wr,
    input  logic [7:0]         cw_data,
    input  logic               rd_en,
    input  logic [1:0]         rd_sel,
    input  logic [CNT_W-1:0]   cnt0_val,
    input  logic [CNT_W-1:0]   cnt1_val,
    input  logic [CNT_W-1:0]   cnt2_val,
    input  logic [NUM_CNT-1:0] out_pin,
    input  logic [NUM_CNT-1:0] null_cnt,
    input  logic [5:0]         ctrl0,
    input  logic [5:0]         ctrl1,
    input  logic [5:0]         ctrl2,
    output logic [7:0]         rd_data,
    output logic               rd_valid
);

    localparam logic [1:0] RW_LSB  = 2'b01;
    localparam logic [1:0] RW_MSB  = 2'b10;
    localparam logic [1:0] RW_BOTH = 2'b11;

    logic [CNT_W-1:0] cnt_val [NUM_CNT];
    logic [5:0]       ctrl    [NUM_CNT];

    assign cnt_val[0] = cnt0_val;
    assign cnt_val[1] = cnt1_val;
    assign cnt_val[2] = cnt2_val;
    assign ctrl[0]    = ctrl0;
    assign ctrl[1]    = ctrl1;
    assign ctrl[2]    = ctrl2;

    // D0 of a read-back command carries no meaning
    logic unused_cw_d0;
    assign unused_cw_d0 = cw_data[0];

    logic [CNT_W-1:0] cnt_lat_q  [NUM_CNT];
    logic [CNT_W-1:0] cnt_lat_d  [NUM_CNT];
    logic [7:0]       sts_lat_q  [NUM_CNT];
    logic [7:0]       sts_lat_d  [NUM_CNT];
    logic [NUM_CNT-1:0] cnt_full_q, cnt_full_d;
    logic [NUM_CNT-1:0] sts_full_q, sts_full_d;
    logic [NUM_CNT-1:0] ptr_msb_q, ptr_msb_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic [CNT_W-1:0] src;

    always_comb begin
        cnt_lat_d  = cnt_lat_q;
        sts_lat_d  = sts_lat_q;
        cnt_full_d = cnt_full_q;
        sts_full_d = sts_full_q;
        ptr_msb_d  = ptr_msb_q;
        rd_data_d  = '0;
        rd_valid_d = rd_en;
        src        = '0;

        // Read resolves against pre-command state; commands below are layered on top
        for (int unsigned n = 0; n < NUM_CNT; n++) begin
            if (rd_en && rd_sel == 2'(n)) begin
                if (sts_full_q[n]) begin
                    rd_data_d     = sts_lat_q[n];
                    sts_full_d[n] = 1'b0;
                end else begin
                    src = cnt_full_q[n] ? cnt_lat_q[n] : cnt_val[n];
                    case (ctrl[n][5:4])
                        RW_LSB: begin
                            rd_data_d     = src[7:0];
                            cnt_full_d[n] = 1'b0;
                        end
                        RW_MSB: begin
                            rd_data_d     = src[15:8];
                            cnt_full_d[n] = 1'b0;
                        end
                        RW_BOTH: begin
                            if (ptr_msb_q[n]) begin
                                rd_data_d     = src[15:8];
                                ptr_msb_d[n]  = 1'b0;
                                cnt_full_d[n] = 1'b0;
                            end else begin
                                rd_data_d    = src[7:0];
                                ptr_msb_d[n] = 1'b1;
                            end
                        end
                        default: rd_data_d = '0;
                    endcase
                end
            end
        end

        for (int unsigned n = 0; n < NUM_CNT; n++) begin
            if (cw_wr) begin
                if (cw_data[7:6] == 2'b11) begin
                    if (cw_data[n+1]) begin
                        if (!cw_data[5] && !cnt_full_d[n]) begin
                            cnt_lat_d[n]  = cnt_val[n];
                            cnt_full_d[n] = 1'b1;
                        end
                        if (!cw_data[4] && !sts_full_d[n]) begin
                            sts_lat_d[n]  = {out_pin[n], null_cnt[n], ctrl[n]};
                            sts_full_d[n] = 1'b1;
                        end
                    end
                end else if (cw_data[7:6] == 2'(n)) begin
                    if (cw_data[5:4] == 2'b00) begin
                        if (!cnt_full_d[n]) begin
                            cnt_lat_d[n]  = cnt_val[n];
                            cnt_full_d[n] = 1'b1;
                        end
                    end else begin
                        cnt_full_d[n] = 1'b0;
                        sts_full_d[n] = 1'b0;
                        ptr_msb_d[n]  = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned n = 0; n < NUM_CNT; n++) begin
                cnt_lat_q[n] <= '0;
                sts_lat_q[n] <= '0;
            end
            cnt_full_q <= '0;
            sts_full_q <= '0;
            ptr_msb_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            for (int unsigned n = 0; n < NUM_CNT; n++) begin
                cnt_lat_q[n] <= cnt_lat_d[n];
                sts_lat_q[n] <= sts_lat_d[n];
            end
            cnt_full_q <= cnt_full_d;
            sts_full_q <= sts_full_d;
            ptr_msb_q  <= ptr_msb_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule
